// File: rtl/ltc_work_sequencer.sv
// Work sequencer for the scrypt core: assembles serial getwork packets, dispatches
// epoch-tagged nonces over a ready/start handshake and queues golden nonces for TX.
module ltc_work_sequencer #(
  parameter int WORK_BYTES   = 84,
  parameter int GAP_CYCLES   = 1000,
  parameter int RESULT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         core_ready,
  output logic         core_start,
  output logic [607:0] core_data,
  output logic [31:0]  core_nonce,
  output logic [1:0]   core_tag,
  input  logic         core_done,
  input  logic [31:0]  core_done_nonce,
  input  logic [1:0]   core_done_tag,
  input  logic [31:0]  core_hash_hi,
  output logic [31:0]  tx_word,
  output logic         tx_send,
  input  logic         tx_busy,
  output logic         work_loaded,
  output logic         nonce_exhausted,
  output logic         result_overflow,
  output logic [15:0]  golden_count
);

  localparam int PKT_W = WORK_BYTES * 8;
  localparam int BC_W  = $clog2(WORK_BYTES);
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam int PTR_W = $clog2(RESULT_DEPTH);

  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(WORK_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(RESULT_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RUN       = 2'd1;
  localparam logic [1:0] S_EXHAUSTED = 2'd2;

  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_WAIT_HI = 2'd1;
  localparam logic [1:0] T_WAIT_LO = 2'd2;

  // Only the first WORK_BYTES-1 bytes are stored; the final byte joins straight from rx_data.
  logic [PKT_W-9:0]  sr;
  logic [PKT_W-1:0]  packet;
  logic [BC_W-1:0]   byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              load;

  logic [31:0]       target;
  logic [31:0]       nonce_next;
  logic [1:0]        epoch;
  logic [1:0]        seq_state;
  logic              dispatch;

  logic [31:0]       fifo_mem [RESULT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              golden;
  logic              push;
  logic              pop;
  logic [1:0]        tx_state;

  assign packet   = {sr, rx_data};
  assign load     = rx_valid && (byte_cnt == LAST_BYTE);
  assign dispatch = (seq_state == S_RUN) && core_ready && !core_start;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else if (rx_valid) begin
      sr       <= packet[PKT_W-9:0];
      gap_cnt  <= '0;
      byte_cnt <= load ? '0 : byte_cnt + 1'b1;
    end else if (byte_cnt != '0) begin
      if (gap_cnt == GAP_LAST) begin
        byte_cnt <= '0;
        gap_cnt  <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target          <= '0;
      nonce_next      <= '0;
      core_data       <= '0;
      epoch           <= '0;
      work_loaded     <= 1'b0;
      nonce_exhausted <= 1'b0;
      seq_state       <= S_IDLE;
      core_start      <= 1'b0;
      core_nonce      <= '0;
      core_tag        <= '0;
    end else begin
      core_start <= 1'b0;
      if (dispatch) begin
        core_start <= 1'b1;
        core_nonce <= nonce_next;
        core_tag   <= epoch;
        nonce_next <= nonce_next + 32'd1;
        if (nonce_next == 32'hFFFF_FFFF) begin
          seq_state       <= S_EXHAUSTED;
          nonce_exhausted <= 1'b1;
        end
      end
      // A load placed after the dispatch wins: this cycle's start used the old work.
      if (load) begin
        target          <= packet[PKT_W-1 -: 32];
        nonce_next      <= packet[PKT_W-33 -: 32];
        core_data       <= packet[607:0];
        epoch           <= epoch + 2'd1;
        work_loaded     <= 1'b1;
        nonce_exhausted <= 1'b0;
        seq_state       <= S_RUN;
      end
    end
  end

  assign golden = core_done && (core_done_tag == epoch) && (core_hash_hi <= target);
  assign pop    = (tx_state == T_IDLE) && (fifo_cnt != '0) && !tx_busy;
  assign push   = golden && ((fifo_cnt != FIFO_FULL) || pop);

  // NOTE: FIFO storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_done_nonce;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      golden_count    <= '0;
      result_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        golden_count <= golden_count + 16'd1;
      end else if (golden) begin
        result_overflow <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_send  <= 1'b0;
      tx_word  <= '0;
    end else begin
      tx_send <= 1'b0;
      case (tx_state)
        T_IDLE: if (pop) begin
          tx_word  <= fifo_mem[rd_ptr];
          tx_send  <= 1'b1;
          tx_state <= T_WAIT_HI;
        end
        T_WAIT_HI: if (tx_busy)  tx_state <= T_WAIT_LO;
        T_WAIT_LO: if (!tx_busy) tx_state <= T_IDLE;
        default:   tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc_work_sequencer.sv
// Directed bench for ltc_work_sequencer: dispatch, golden results, gap discard,
// stale epochs, nonce exhaustion, FIFO overflow and mid-packet reset.
module tb_ltc_work_sequencer;

  localparam int GAP_CYCLES = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         core_ready = 1'b0;
  logic         core_start;
  logic [607:0] core_data;
  logic [31:0]  core_nonce;
  logic [1:0]   core_tag;
  logic         core_done = 1'b0;
  logic [31:0]  core_done_nonce = '0;
  logic [1:0]   core_done_tag = '0;
  logic [31:0]  core_hash_hi = '0;
  logic [31:0]  tx_word;
  logic         tx_send;
  logic         tx_busy;
  logic         work_loaded;
  logic         nonce_exhausted;
  logic         result_overflow;
  logic [15:0]  golden_count;

  ltc_work_sequencer #(
    .WORK_BYTES   (84),
    .GAP_CYCLES   (GAP_CYCLES),
    .RESULT_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .core_ready      (core_ready),
    .core_start      (core_start),
    .core_data       (core_data),
    .core_nonce      (core_nonce),
    .core_tag        (core_tag),
    .core_done       (core_done),
    .core_done_nonce (core_done_nonce),
    .core_done_tag   (core_done_tag),
    .core_hash_hi    (core_hash_hi),
    .tx_word         (tx_word),
    .tx_send         (tx_send),
    .tx_busy         (tx_busy),
    .work_loaded     (work_loaded),
    .nonce_exhausted (nonce_exhausted),
    .result_overflow (result_overflow),
    .golden_count    (golden_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        tx_hold = 1'b0;
  int          busy_cnt = 0;

  // Transmitter model: busy rises the cycle after tx_send and stays up for three cycles.
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = tx_hold || (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [607:0] obs, input logic [607:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transmitted word must be the oldest expected golden nonce.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_send === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'(tx_send), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_word", tx_word, mon_exp);
      end
    end
  end

  function automatic logic [607:0] make_hdr(input logic [31:0] seed);
    logic [607:0] h;
    for (int i = 0; i < 19; i++)
      h[32*i +: 32] = (i == 0) ? 32'h0100_0000 : seed ^ (32'(i) * 32'h0101_0101);
    return h;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input logic [671:0] pkt, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pkt[671 - 8*i -: 8]);
  endtask

  task automatic load_work(input logic [31:0] tgt, input logic [31:0] nonce, input logic [607:0] hdr);
    send_range({tgt, nonce, hdr}, 0, 83);
  endtask

  task automatic expect_start(input string tag, input logic [31:0] nonce, input logic [1:0] etag,
                              output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (core_start) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      check({tag, "_timeout"}, 32'(core_start), 32'd1);
    end else begin
      check({tag, "_nonce"}, core_nonce, nonce);
      check({tag, "_tag"}, 32'(core_tag), 32'(etag));
    end
  endtask

  task automatic core_result(input logic [31:0] nonce, input logic [1:0] tag, input logic [31:0] hash);
    core_done       = 1'b1;
    core_done_nonce = nonce;
    core_done_tag   = tag;
    core_hash_hi    = hash;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [607:0] hdr_a, hdr_b, hdr_c;
    logic [671:0] pkt;
    int           lat, n;
    hdr_a = make_hdr(32'hA5A5_0001);
    hdr_b = make_hdr(32'h3C3C_0002);
    hdr_c = make_hdr(32'h0F0F_0003);

    // Reset state
    step(3);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_work_loaded", 32'(work_loaded), 32'd0);
    check("rst_golden_count", 32'(golden_count), 32'd0);
    check_data("rst_core_data", core_data, '0);
    rst_n = 1'b1;
    step(2);

    // Load work A and observe the dispatch stream
    pkt = {32'h0000_07ff, 32'h0000_318e, hdr_a};
    core_ready = 1'b1;
    send_range(pkt, 0, 82);
    check("a_not_loaded_early", 32'(work_loaded), 32'd0);
    send_range(pkt, 83, 83);
    check("a_work_loaded", 32'(work_loaded), 32'd1);
    check_data("a_core_data", core_data, hdr_a);
    expect_start("a_start0", 32'h0000_318e, 2'd1, lat);
    check("a_start0_latency", 32'(lat), 32'd1);
    expect_start("a_start1", 32'h0000_318f, 2'd1, lat);
    check("a_start_spacing", 32'(lat), 32'd2);
    core_ready = 1'b0;
    step(2);

    // Golden at hash == target, then a hash just above target
    exp_q.push_back(32'h0000_318f);
    core_result(32'h0000_318f, 2'd1, 32'h0000_07ff);
    check("golden_count_1", 32'(golden_count), 32'd1);
    wait_drain("golden_tx", 30);
    core_result(32'h0000_3190, 2'd1, 32'h0000_0800);
    step(10);
    check("above_target_ignored", 32'(golden_count), 32'd1);

    // Partial packet abandoned after the gap; latched work untouched
    for (int i = 0; i < 40; i++) send_byte(8'hA5 ^ 8'(i));
    step(GAP_CYCLES + 1);
    check("gap_keeps_loaded", 32'(work_loaded), 32'd1);
    check_data("gap_keeps_data", core_data, hdr_a);
    load_work(32'hFFFF_FFFF, 32'h0000_1000, hdr_c);
    check_data("gap_then_load_data", core_data, hdr_c);
    core_ready = 1'b1;
    expect_start("c_start", 32'h0000_1000, 2'd2, lat);
    core_ready = 1'b0;
    step(2);

    // Two back-to-back loads; a result for the older epoch is dropped
    load_work(32'hFFFF_FFFF, 32'h0000_2000, hdr_a);
    load_work(32'hFFFF_FFFF, 32'h55AA_0000, hdr_b);
    core_result(32'h0000_2000, 2'd3, 32'h0000_0000);
    step(10);
    check("stale_ignored", 32'(golden_count), 32'd1);
    core_ready = 1'b1;
    expect_start("b_start", 32'h55AA_0000, 2'd0, lat);
    core_ready = 1'b0;
    step(2);

    // Nonce space exhaustion
    load_work(32'hFFFF_FFFF, 32'hFFFF_FFFE, hdr_a);
    check("exh_clear_before", 32'(nonce_exhausted), 32'd0);
    core_ready = 1'b1;
    expect_start("exh_start0", 32'hFFFF_FFFE, 2'd1, lat);
    expect_start("exh_start1", 32'hFFFF_FFFF, 2'd1, lat);
    check("exh_flag", 32'(nonce_exhausted), 32'd1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (core_start) n++;
    end
    check("exh_no_starts", 32'(n), 32'd0);
    core_ready = 1'b0;

    // New work clears exhaustion; fill the FIFO past depth while TX is held busy
    load_work(32'hFFFF_FFFF, 32'h0000_0000, hdr_c);
    check("exh_cleared_on_load", 32'(nonce_exhausted), 32'd0);
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0000_00A0 + 32'(i));
      core_result(32'h0000_00A0 + 32'(i), 2'd2, 32'h1234_5678);
    end
    check("ovf_not_yet", 32'(result_overflow), 32'd0);
    core_result(32'h0000_00A4, 2'd2, 32'h1234_5678);
    check("ovf_set", 32'(result_overflow), 32'd1);
    check("ovf_golden_count", 32'(golden_count), 32'd5);
    step(5);
    tx_hold = 1'b0;
    wait_drain("ovf_drain", 100);
    check("ovf_sticky", 32'(result_overflow), 32'd1);

    // Reset in the middle of a packet clears everything
    pkt = {32'hFFFF_FFFF, 32'h0000_0077, hdr_b};
    send_range(pkt, 0, 19);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_loaded", 32'(work_loaded), 32'd0);
    check("mid_rst_overflow", 32'(result_overflow), 32'd0);
    check("mid_rst_golden", 32'(golden_count), 32'd0);
    check_data("mid_rst_data", core_data, '0);
    step(2);
    rst_n = 1'b1;
    step(1);
    load_work(32'hFFFF_FFFF, 32'h0000_0077, hdr_b);
    check_data("post_rst_data", core_data, hdr_b);
    core_ready = 1'b1;
    expect_start("post_rst_start", 32'h0000_0077, 2'd1, lat);
    core_ready = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
